// File: rtl/tap_delay_line.sv
// Tap storage for the FIR datapath: a DEPTH-deep shift line with a valid/ready
// input, fill count, registered random-access read and a lossless ROTATE walk.
module tap_delay_line #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   rot_start,
    output logic                   busy,
    output logic [IDXW-1:0]        rot_idx,
    output logic [WIDTH-1:0]       head,
    output logic                   rot_done,
    output logic [WIDTH*DEPTH-1:0] taps_flat,
    input  logic [IDXW-1:0]        rd_idx,
    output logic [WIDTH-1:0]       rd_data,
    output logic [IDXW:0]          count,
    output logic                   primed
);

    typedef enum logic {IDLE, ROTATE} state_t;

    state_t                          state;
    logic   [DEPTH-1:0][WIDTH-1:0]   tap;

    assign in_ready  = (state == IDLE) && !rot_start;
    assign busy      = (state == ROTATE);
    assign head      = tap[DEPTH-1];
    assign taps_flat = tap;
    assign primed    = (count == (IDXW+1)'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tap      <= '0;
            count    <= '0;
            rot_idx  <= '0;
            rot_done <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            tap      <= '0;
            count    <= '0;
            rot_idx  <= '0;
            rot_done <= 1'b0;
        end else begin
            rot_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rot_start) begin
                        state   <= ROTATE;
                        rot_idx <= '0;
                    end else if (in_valid) begin
                        tap <= {tap[DEPTH-2:0], in_data};
                        if (!primed)
                            count <= count + (IDXW+1)'(1);
                    end
                end
                ROTATE: begin
                    // DEPTH recirculating shifts bring every tap back home.
                    tap <= {tap[DEPTH-2:0], tap[DEPTH-1]};
                    if (rot_idx == IDXW'(DEPTH-1)) begin
                        state    <= IDLE;
                        rot_idx  <= '0;
                        rot_done <= 1'b1;
                    end else begin
                        rot_idx <= rot_idx + IDXW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read port samples the pre-edge taps regardless of clear or rotation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_data <= '0;
        else if ({1'b0, rd_idx} < (IDXW+1)'(DEPTH))
            rd_data <= tap[rd_idx];
        else
            rd_data <= '0;
    end

endmodule

// File: tb/tb_tap_delay_line.sv
// Randomised bench for tap_delay_line (WIDTH=8, DEPTH=4) against a queue-style
// model of the tap line.
module tb_tap_delay_line;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         rot_start = 1'b0;
    logic         busy;
    logic [1:0]   rot_idx;
    logic [W-1:0] head;
    logic         rot_done;
    logic [W*D-1:0] taps_flat;
    logic [1:0]   rd_idx = '0;
    logic [W-1:0] rd_data;
    logic [2:0]   count;
    logic         primed;

    tap_delay_line #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .rot_start(rot_start),
        .busy(busy), .rot_idx(rot_idx), .head(head), .rot_done(rot_done),
        .taps_flat(taps_flat), .rd_idx(rd_idx), .rd_data(rd_data),
        .count(count), .primed(primed)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total = 0;

    // Model: m[0] is the newest sample, m[D-1] the oldest.
    logic [W-1:0] m[D];
    int           m_cnt;

    function automatic logic [W*D-1:0] m_flat();
        logic [W*D-1:0] f;
        for (int i = 0; i < D; i++) f[i*W +: W] = m[i];
        return f;
    endfunction

    function automatic void m_zero();
        for (int i = 0; i < D; i++) m[i] = '0;
        m_cnt = 0;
    endfunction

    function automatic void m_push(logic [W-1:0] d);
        for (int i = D-1; i > 0; i--) m[i] = m[i-1];
        m[0] = d;
        if (m_cnt < D) m_cnt++;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        in_valid = 1'b1; in_data = d;
        cyc();
        in_valid = 1'b0;
        m_push(d);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        m_zero();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        total++; if (taps_flat !== '0) $display("FAIL reset_taps got %h want 0", taps_flat); else pass_cnt++;
        total++; if (count !== 3'd0 || primed !== 1'b0) $display("FAIL reset_count got %0d/%b want 0/0", count, primed); else pass_cnt++;
        total++; if ({rd_data, rot_idx, rot_done, busy} !== '0) $display("FAIL reset_misc got rd=%h idx=%0d done=%b busy=%b want 0", rd_data, rot_idx, rot_done, busy); else pass_cnt++;
        reset = 1'b1;
        m_zero();
        cyc();
    endtask

    task automatic test_fill();
        push(8'h11); push(8'h22); push(8'h33);
        total++; if (count !== 3'd3 || primed !== 1'b0) $display("FAIL fill3 got count=%0d primed=%b want 3/0", count, primed); else pass_cnt++;
        push(8'h44);
        total++; if (taps_flat !== 32'h11223344) $display("FAIL fill4_taps got %h want 11223344", taps_flat); else pass_cnt++;
        total++; if (primed !== 1'b1 || head !== 8'h11) $display("FAIL fill4_primed got primed=%b head=%h want 1/11", primed, head); else pass_cnt++;
        push(8'h55);
        total++; if (taps_flat[3*W +: W] !== 8'h22 || count !== 3'd4) $display("FAIL fill5 got tap3=%h count=%0d want 22/4", taps_flat[3*W +: W], count); else pass_cnt++;
        total++; if (taps_flat !== m_flat()) $display("FAIL fill5_taps got %h want %h", taps_flat, m_flat()); else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [W*D-1:0] orig;
        do_clear();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        orig = m_flat();
        rot_start = 1'b1;
        cyc();
        rot_start = 1'b0;
        for (int k = 0; k < D; k++) begin
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || rot_idx !== 2'(k) || head !== m[D-1-k] || rot_done !== 1'b0)
                $display("FAIL rot_cycle%0d got busy=%b rdy=%b idx=%0d head=%h done=%b want 1/0/%0d/%h/0",
                         k, busy, in_ready, rot_idx, head, rot_done, k, m[D-1-k]);
            else pass_cnt++;
            cyc();
        end
        total++; if (rot_done !== 1'b1 || busy !== 1'b0 || rot_idx !== 2'd0) $display("FAIL rot_done got done=%b busy=%b idx=%0d want 1/0/0", rot_done, busy, rot_idx); else pass_cnt++;
        total++; if (taps_flat !== orig || count !== 3'd4) $display("FAIL rot_restore got %h/%0d want %h/4", taps_flat, count, orig); else pass_cnt++;
        cyc();
        total++; if (rot_done !== 1'b0) $display("FAIL rot_done_pulse got %b want 0", rot_done); else pass_cnt++;
    endtask

    task automatic test_stall();
        // rot_start and in_valid together: rotation wins, 0x66 waits.
        in_valid = 1'b1; in_data = 8'h66; rot_start = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_start_ready got %b want 0", in_ready); else pass_cnt++;
        cyc();
        rot_start = 1'b0;
        total++; if (head !== m[D-1] || busy !== 1'b1) $display("FAIL stall_no_take got head=%h busy=%b want %h/1", head, busy, m[D-1]); else pass_cnt++;
        for (int k = 0; k < D; k++) begin
            total++; if (in_ready !== 1'b0) $display("FAIL stall_ready%0d got %b want 0", k, in_ready); else pass_cnt++;
            cyc();
        end
        total++; if (rot_done !== 1'b1 || in_ready !== 1'b1) $display("FAIL stall_donecyc got done=%b rdy=%b want 1/1", rot_done, in_ready); else pass_cnt++;
        cyc();
        in_valid = 1'b0;
        m_push(8'h66);
        total++; if (taps_flat !== m_flat() || count !== 3'(m_cnt)) $display("FAIL stall_accept got %h/%0d want %h/%0d", taps_flat, count, m_flat(), m_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [W*D-1:0] orig;
        orig = m_flat();
        in_valid = 1'b1; in_data = 8'h77; rot_start = 1'b1;
        cyc();
        for (int k = 0; k < D; k++) cyc();
        total++; if (rot_done !== 1'b1 || in_ready !== 1'b0) $display("FAIL b2b_done got done=%b rdy=%b want 1/0", rot_done, in_ready); else pass_cnt++;
        cyc();
        rot_start = 1'b0;
        total++; if (busy !== 1'b1 || rot_idx !== 2'd0 || taps_flat !== orig) $display("FAIL b2b_reenter got busy=%b idx=%0d taps=%h want 1/0/%h", busy, rot_idx, taps_flat, orig); else pass_cnt++;
        in_valid = 1'b0;
        for (int k = 0; k < D; k++) cyc();
        total++; if (rot_done !== 1'b1 || taps_flat !== orig) $display("FAIL b2b_end got done=%b taps=%h want 1/%h", rot_done, taps_flat, orig); else pass_cnt++;
        cyc();
    endtask

    task automatic test_clear_abort();
        in_valid = 1'b1; in_data = 8'h99; clear = 1'b1;
        cyc();
        in_valid = 1'b0; clear = 1'b0;
        m_zero();
        total++; if (taps_flat !== '0 || count !== 3'd0) $display("FAIL clear_valid got %h/%0d want 0/0", taps_flat, count); else pass_cnt++;
        push(8'hA1); push(8'hB2); push(8'hC3);
        rot_start = 1'b1;
        cyc();
        rot_start = 1'b0;
        cyc(); cyc();
        total++; if (rot_idx !== 2'd2) $display("FAIL abort_idx got %0d want 2", rot_idx); else pass_cnt++;
        do_clear();
        total++; if (busy !== 1'b0 || taps_flat !== '0 || rot_done !== 1'b0 || rot_idx !== 2'd0 || count !== 3'd0)
            $display("FAIL abort_clear got busy=%b taps=%h done=%b idx=%0d cnt=%0d want 0", busy, taps_flat, rot_done, rot_idx, count);
        else pass_cnt++;
        cyc();
        total++; if (rot_done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_nodone got done=%b busy=%b want 0/0", rot_done, busy); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        push(8'hD4); push(8'hE5);
        rd_idx = 2'd0;
        rot_start = 1'b1;
        cyc();
        rot_start = 1'b0;
        cyc();
        total++; if (rot_idx !== 2'd1) $display("FAIL rst_abort_idx got %0d want 1", rot_idx); else pass_cnt++;
        reset = 1'b0;
        #1;
        total++; if ({taps_flat, head, rot_idx, busy, count, rd_data, rot_done, primed} !== '0)
            $display("FAIL rst_abort got taps=%h head=%h idx=%0d busy=%b cnt=%0d rd=%h done=%b want 0", taps_flat, head, rot_idx, busy, count, rd_data, rot_done);
        else pass_cnt++;
        #1;
        reset = 1'b1;
        m_zero();
        cyc();
    endtask

    task automatic test_read_port();
        for (int i = 0; i < D; i++) push(8'($urandom));
        rd_idx = 2'd2;
        cyc();
        total++; if (rd_data !== m[2]) $display("FAIL rd_idx2 got %h want %h", rd_data, m[2]); else pass_cnt++;
        for (int i = 0; i < D; i++) begin
            rd_idx = 2'(i);
            cyc();
            total++; if (rd_data !== m[i] || rd_data !== taps_flat[i*W +: W]) $display("FAIL rd_sweep%0d got %h want %h", i, rd_data, m[i]); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] prev[D];
        logic [W-1:0] d;
        int op;
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                do_clear();
                total++; if (taps_flat !== '0 || count !== 3'd0) $display("FAIL rnd_clear%0d got %h/%0d want 0/0", it, taps_flat, count); else pass_cnt++;
            end else if (op == 1) begin
                prev = m;
                rot_start = 1'b1;
                cyc();
                rot_start = 1'b0;
                for (int k = 0; k < D; k++) begin
                    total++; if (head !== prev[D-1-k] || rot_idx !== 2'(k)) $display("FAIL rnd_rot%0d_%0d got head=%h idx=%0d want %h/%0d", it, k, head, rot_idx, prev[D-1-k], k); else pass_cnt++;
                    cyc();
                end
                total++; if (rot_done !== 1'b1 || taps_flat !== m_flat()) $display("FAIL rnd_rotend%0d got done=%b taps=%h want 1/%h", it, rot_done, taps_flat, m_flat()); else pass_cnt++;
            end else begin
                prev = m;
                d = 8'($urandom);
                in_valid = 1'($urandom_range(0, 1));
                in_data = d;
                rd_idx = 2'($urandom_range(0, D-1));
                cyc();
                if (in_valid) m_push(d);
                in_valid = 1'b0;
                total++; if (taps_flat !== m_flat() || count !== 3'(m_cnt) || primed !== (m_cnt == D))
                    $display("FAIL rnd_step%0d got %h/%0d/%b want %h/%0d", it, taps_flat, count, primed, m_flat(), m_cnt);
                else pass_cnt++;
                total++; if (rd_data !== prev[rd_idx]) $display("FAIL rnd_rd%0d got %h want %h", it, rd_data, prev[rd_idx]); else pass_cnt++;
            end
        end
    endtask

    initial begin
        m_zero();
        test_reset();
        test_fill();
        test_rotation();
        test_stall();
        test_back_to_back();
        test_clear_abort();
        test_reset_abort();
        test_read_port();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

endmodule

// File: doc/tap_delay_line.md
# tap_delay_line

Parametrised tap storage for the FIR datapath, replacing the per-tap registers. Holds the last DEPTH input samples as a shift line with a valid/ready input handshake, synchronous clear, fill tracking and a registered random-access read port. A ROTATE mode circulates all taps past a single output so that one pipelined multiplier can walk every tap, then leaves the line exactly as it was.

## Interface
- WIDTH, 16, sample width in bits
- DEPTH, 8, number of taps (≥2)
- IDXW, $clog2(DEPTH), index width (derived; not overridden)

- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of taps, count and state
- in_valid  in  1  in_data is valid
- in_ready  out  1  line accepts a sample this cycle
- in_data  in  WIDTH  new sample
- rot_start  in  1  request one full rotation
- busy  out  1  high while in ROTATE
- rot_idx  out  IDXW  rotation step, 0..DEPTH-1 in ROTATE, else 0
- head  out  WIDTH  tap[DEPTH-1], combinational from the tap registers
- rot_done  out  1  one-cycle pulse after a completed rotation
- taps_flat  out  WIDTH*DEPTH  tap[i] at bits [i*WIDTH +: WIDTH]
- rd_idx  in  IDXW  read index
- rd_data  out  WIDTH  registered tap[rd_idx]
- count  out  IDXW+1  samples held, saturates at DEPTH
- primed  out  1  count == DEPTH

## Operation
- Reset (reset=0): all taps, count, rd_data, rot_idx and rot_done go to 0. State goes to IDLE. The reset acts immediately, mid-rotation included.
- States:
  - IDLE: in_ready = !rot_start.
  - ROTATE: in_ready = 0 and busy = 1.
- Priority at each edge: clear > rot_start (IDLE only) > accepted sample.
- Sample accept (IDLE, in_valid && in_ready):
  - tap[0] <= in_data and tap[i] <= tap[i-1].
  - The old tap[DEPTH-1] is dropped.
  - count <= min(count+1, DEPTH).
- rot_start in IDLE enters ROTATE with rot_idx=0. No sample is taken that cycle, because in_ready is low.
- ROTATE, each edge:
  - tap[0] <= tap[DEPTH-1] and tap[i] <= tap[i-1].
  - rot_idx increments.
  - On the edge where rot_idx==DEPTH-1, the state returns to IDLE, rot_idx goes to 0 and rot_done goes high for one cycle.
- rot_start is ignored in ROTATE. in_valid held during ROTATE is stalled, not lost.
- clear:
  - Zeroes taps and count, sets state to IDLE, rot_idx to 0 and rot_done to 0.
  - A rotation aborted by clear produces no rot_done.
  - rd_data still updates from the post-clear taps on the next edge.
- rd_data <= tap[rd_idx] every edge, in any state. If rd_idx ≥ DEPTH, rd_data <= 0.
- count is unchanged by rotation. primed is derived combinationally from count.

## Timing
- Sample visible on taps_flat, head and count: 1 cycle after the accepting edge.
- rd_data latency: 1 cycle from rd_idx. It reflects the taps as they were before that edge's update.
- ROTATE lasts exactly DEPTH cycles.
- In ROTATE cycle k, head = original tap[DEPTH-1-k] and rot_idx = k.
- rot_done is high in the first IDLE cycle after ROTATE. in_ready can be high in that same cycle.
- After rotation, all taps equal their pre-rotation values.
- Back-to-back: rot_start held high re-enters ROTATE on the rot_done cycle. No sample is accepted in between.
- There is no combinational path from in_valid to in_ready.

## Test plan
Benches use WIDTH=8, DEPTH=4.
- Reset then fill: push 0x11, 0x22, 0x33 → count=3, primed=0. Push 0x44 → taps = {0x44, 0x33, 0x22, 0x11} (tap[0] first), primed=1. Push 0x55 → tap[3]=0x22, count stays 4.
- Rotation: with taps {0x44, 0x33, 0x22, 0x11}, pulse rot_start → busy for 4 cycles with head = 0x11, 0x22, 0x33, 0x44 and rot_idx = 0..3. rot_done is high for 1 cycle, then taps are restored.
- Stall: hold in_valid with 0x66 across a rotation → in_ready stays low for all 4 busy cycles. 0x66 is accepted in the rot_done cycle.
- Simultaneous events:
  - rot_start and in_valid together in IDLE → rotation starts and no sample is taken.
  - clear and in_valid together → taps and count become 0.
- Abort: clear at rot_idx=2 → IDLE next cycle, taps all 0, no rot_done. Async reset low at rot_idx=1 → all outputs 0 immediately.
- Read port: rd_idx=2 → rd_data = tap[2] one cycle later. Sweep rd_idx over 0..3 and check each value against taps_flat.
